// File: rtl/wb_ibus_dbus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ibus_dbus_arbiter
//
// Merges the Atom core's IBUS and DBUS Wishbone master ports onto one shared
// Wishbone master port. One requester is granted at a time. The grant is held
// for the whole bus cycle, and ack/data are returned only to the granted side.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit, in cycles, for an unacknowledged granted
//                   cycle (0 = watchdog disabled)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate, starting
//                                    with IBUS after reset
//                       undefined -> DBUS wins every tie
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   ibus_wb_*                IBUS slave-side port (read only)
//   dbus_wb_*                DBUS slave-side port (read/write)
//   m_wb_*                   shared master port towards memory/interconnect
//   timeout_o                one-cycle pulse when the watchdog ends a cycle
// -----------------------------------------------------------------------------
module wb_ibus_dbus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // IBUS
  input  logic [31:0] ibus_wb_adr_i,
  output logic [31:0] ibus_wb_dat_o,
  input  logic        ibus_wb_cyc_i,
  input  logic        ibus_wb_stb_i,
  output logic        ibus_wb_ack_o,
  // DBUS
  input  logic [31:0] dbus_wb_adr_i,
  input  logic [31:0] dbus_wb_dat_i,
  output logic [31:0] dbus_wb_dat_o,
  input  logic        dbus_wb_cyc_i,
  input  logic        dbus_wb_stb_i,
  input  logic        dbus_wb_we_i,
  input  logic [3:0]  dbus_wb_sel_i,
  output logic        dbus_wb_ack_o,
  // Shared master port
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  input  logic [31:0] m_wb_dat_i,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_we_o,
  output logic [3:0]  m_wb_sel_o,
  input  logic        m_wb_ack_i,
  // Watchdog
  output logic        timeout_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0] gnt_q, gnt_d;
  logic       ibus_req, dbus_req;
  logic       tie_to_ibus;
  logic       gnt_cyc;      // cyc of the currently granted requester
  logic       timeout_hit;

  assign ibus_req = ibus_wb_cyc_i & ibus_wb_stb_i;
  assign dbus_req = dbus_wb_cyc_i & dbus_wb_stb_i;

  always_comb begin
    gnt_cyc = 1'b0;
    case (gnt_q)
      GNT_I:   gnt_cyc = ibus_wb_cyc_i;
      GNT_D:   gnt_cyc = dbus_wb_cyc_i;
      default: gnt_cyc = 1'b0;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who was served last; resets to DBUS so IBUS wins the first tie.
  logic last_dbus_q, last_dbus_d;

  always_comb begin
    last_dbus_d = last_dbus_q;
    if (gnt_q == IDLE) begin
      if (gnt_d == GNT_I) last_dbus_d = 1'b0;
      if (gnt_d == GNT_D) last_dbus_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) last_dbus_q <= 1'b1;
    else          last_dbus_q <= last_dbus_d;
  end

  assign tie_to_ibus = last_dbus_q;
`else
  assign tie_to_ibus = 1'b0;
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

      logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

      always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (gnt_q == IDLE)    wd_cnt_d = '0;
        else if (!m_wb_ack_i) wd_cnt_d = wd_cnt_q + WD_W'(1);
      end

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) wd_cnt_q <= '0;
        else          wd_cnt_q <= wd_cnt_d;
      end

      // A real ack, or an abort by the requester, takes precedence.
      assign timeout_hit = gnt_cyc & ~m_wb_ack_i &
                           (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wd
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    gnt_d = gnt_q;
    case (gnt_q)
      IDLE: begin
        if (ibus_req && dbus_req) gnt_d = tie_to_ibus ? GNT_I : GNT_D;
        else if (ibus_req)        gnt_d = GNT_I;
        else if (dbus_req)        gnt_d = GNT_D;
      end
      GNT_I, GNT_D: begin
        if (m_wb_ack_i || !gnt_cyc || timeout_hit) gnt_d = IDLE;
      end
      default: gnt_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) gnt_q <= IDLE;
    else          gnt_q <= gnt_d;
  end

  always_comb begin
    m_wb_adr_o    = '0;
    m_wb_dat_o    = '0;
    m_wb_cyc_o    = 1'b0;
    m_wb_stb_o    = 1'b0;
    m_wb_we_o     = 1'b0;
    m_wb_sel_o    = '0;
    ibus_wb_ack_o = 1'b0;
    dbus_wb_ack_o = 1'b0;
    ibus_wb_dat_o = m_wb_dat_i;
    dbus_wb_dat_o = m_wb_dat_i;
    timeout_o     = timeout_hit;
    case (gnt_q)
      GNT_I: begin
        m_wb_adr_o    = ibus_wb_adr_i;
        m_wb_sel_o    = '1;
        m_wb_cyc_o    = ibus_wb_cyc_i & ~timeout_hit;
        m_wb_stb_o    = ibus_wb_stb_i & ~timeout_hit;
        ibus_wb_ack_o = (m_wb_ack_i & ibus_wb_cyc_i) | timeout_hit;
        if (timeout_hit) ibus_wb_dat_o = '0;
      end
      GNT_D: begin
        m_wb_adr_o    = dbus_wb_adr_i;
        m_wb_dat_o    = dbus_wb_dat_i;
        m_wb_we_o     = dbus_wb_we_i;
        m_wb_sel_o    = dbus_wb_sel_i;
        m_wb_cyc_o    = dbus_wb_cyc_i & ~timeout_hit;
        m_wb_stb_o    = dbus_wb_stb_i & ~timeout_hit;
        dbus_wb_ack_o = (m_wb_ack_i & dbus_wb_cyc_i) | timeout_hit;
        if (timeout_hit) dbus_wb_dat_o = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_ibus_dbus_arbiter.sv
module tb_wb_ibus_dbus_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] ibus_wb_adr_i, ibus_wb_dat_o;
  logic        ibus_wb_cyc_i, ibus_wb_stb_i, ibus_wb_ack_o;
  logic [31:0] dbus_wb_adr_i, dbus_wb_dat_i, dbus_wb_dat_o;
  logic        dbus_wb_cyc_i, dbus_wb_stb_i, dbus_wb_we_i, dbus_wb_ack_o;
  logic [3:0]  dbus_wb_sel_i;
  logic [31:0] m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
  logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_ack_i;
  logic [3:0]  m_wb_sel_o;
  logic        timeout_o;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_ibus_dbus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .ibus_wb_adr_i(ibus_wb_adr_i), .ibus_wb_dat_o(ibus_wb_dat_o),
    .ibus_wb_cyc_i(ibus_wb_cyc_i), .ibus_wb_stb_i(ibus_wb_stb_i),
    .ibus_wb_ack_o(ibus_wb_ack_o),
    .dbus_wb_adr_i(dbus_wb_adr_i), .dbus_wb_dat_i(dbus_wb_dat_i),
    .dbus_wb_dat_o(dbus_wb_dat_o), .dbus_wb_cyc_i(dbus_wb_cyc_i),
    .dbus_wb_stb_i(dbus_wb_stb_i), .dbus_wb_we_i(dbus_wb_we_i),
    .dbus_wb_sel_i(dbus_wb_sel_i), .dbus_wb_ack_o(dbus_wb_ack_o),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_we_o(m_wb_we_o),
    .m_wb_sel_o(m_wb_sel_o), .m_wb_ack_i(m_wb_ack_i),
    .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic        icyc, istb;
    logic [31:0] iadr;
    logic        dcyc, dstb, dwe;
    logic [3:0]  dsel;
    logic [31:0] dadr, ddat;
    logic        sack;
    logic [31:0] sdat;
  } in_t;

  typedef struct packed {
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        iack, dack;
    logic [31:0] idat, ddat;
    logic        tmo;
  } out_t;

  typedef struct {
    in_t  vi;
    out_t ve;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  out_t exp_q[$];
  int   gnt_q[$];

  function automatic in_t i_none(logic [31:0] sdat, logic sack);
    in_t x;
    x = '0;
    x.sdat = sdat;
    x.sack = sack;
    return x;
  endfunction

  function automatic in_t i_ibus(logic [31:0] adr, logic [31:0] sdat);
    in_t x;
    x = i_none(sdat, 1'b0);
    x.icyc = 1'b1;
    x.istb = 1'b1;
    x.iadr = adr;
    return x;
  endfunction

  function automatic in_t i_dbus(logic [31:0] adr, logic [31:0] dat, logic we,
                                 logic [3:0] sel, logic [31:0] sdat);
    in_t x;
    x = i_none(sdat, 1'b0);
    x.dcyc = 1'b1;
    x.dstb = 1'b1;
    x.dwe  = we;
    x.dsel = sel;
    x.dadr = adr;
    x.ddat = dat;
    return x;
  endfunction

  function automatic out_t o_idle(logic [31:0] sdat);
    out_t e;
    e = '0;
    e.idat = sdat;
    e.ddat = sdat;
    return e;
  endfunction

  function automatic out_t o_ibus(logic [31:0] adr, logic cyc, logic stb,
                                  logic ack, logic [31:0] sdat);
    out_t e;
    e = o_idle(sdat);
    e.cyc  = cyc;
    e.stb  = stb;
    e.sel  = 4'hF;
    e.adr  = adr;
    e.iack = ack;
    return e;
  endfunction

  function automatic out_t o_dbus(in_t x, logic ack);
    out_t e;
    e = o_idle(x.sdat);
    e.cyc  = x.dcyc;
    e.stb  = x.dstb;
    e.we   = x.dwe;
    e.sel  = x.dsel;
    e.adr  = x.dadr;
    e.dat  = x.ddat;
    e.dack = ack;
    return e;
  endfunction

  function automatic void add(in_t x, out_t e);
    vec_t v;
    v.vi = x;
    v.ve = e;
    vecs.push_back(v);
  endfunction

  task automatic drive(in_t x);
    ibus_wb_cyc_i = x.icyc;
    ibus_wb_stb_i = x.istb;
    ibus_wb_adr_i = x.iadr;
    dbus_wb_cyc_i = x.dcyc;
    dbus_wb_stb_i = x.dstb;
    dbus_wb_we_i  = x.dwe;
    dbus_wb_sel_i = x.dsel;
    dbus_wb_adr_i = x.dadr;
    dbus_wb_dat_i = x.ddat;
    m_wb_ack_i    = x.sack;
    m_wb_dat_i    = x.sdat;
  endtask

  function automatic out_t sample();
    out_t a;
    a.cyc  = m_wb_cyc_o;
    a.stb  = m_wb_stb_o;
    a.we   = m_wb_we_o;
    a.sel  = m_wb_sel_o;
    a.adr  = m_wb_adr_o;
    a.dat  = m_wb_dat_o;
    a.iack = ibus_wb_ack_o;
    a.dack = dbus_wb_ack_o;
    a.idat = ibus_wb_dat_o;
    a.ddat = dbus_wb_dat_o;
    a.tmo  = timeout_o;
    return a;
  endfunction

  task automatic check_out(string name, out_t e);
    out_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h iack=%b dack=%b idat=%h ddat=%h tmo=%b | want cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h iack=%b dack=%b idat=%h ddat=%h tmo=%b",
               name, a.cyc, a.stb, a.we, a.sel, a.adr, a.dat, a.iack, a.dack, a.idat, a.ddat, a.tmo,
               e.cyc, e.stb, e.we, e.sel, e.adr, e.dat, e.iack, e.dack, e.idat, e.ddat, e.tmo);
    end
  endtask

  task automatic check_bits(string name, logic [3:0] act, logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    in_t  x, y;
    out_t e;

    // ---------------- vector table ----------------
    // IBUS read of 0x100, slave answers 0x13 one cycle after stb
    x = i_ibus(32'h0000_0100, 32'h0000_0013);
    add(x, o_idle(32'h13));
    add(x, o_ibus(32'h100, 1'b1, 1'b1, 1'b0, 32'h13));
    x.sack = 1'b1;
    add(x, o_ibus(32'h100, 1'b1, 1'b1, 1'b1, 32'h13));
    // slave ack arriving while IDLE is ignored
    add(i_none(32'h13, 1'b1), o_idle(32'h13));
    // DBUS write
    y = i_dbus(32'h2000_0004, 32'hCAFE_BABE, 1'b1, 4'b0011, 32'h11);
    add(y, o_idle(32'h11));
    add(y, o_dbus(y, 1'b0));
    y.sack = 1'b1;
    add(y, o_dbus(y, 1'b1));
    add(i_none(32'h0, 1'b0), o_idle(32'h0));
    // DBUS abort with IBUS pending
    y = i_dbus(32'h3000_0000, 32'h0, 1'b0, 4'hF, 32'h22);
    add(y, o_idle(32'h22));
    y.icyc = 1'b1; y.istb = 1'b1; y.iadr = 32'h400;
    add(y, o_dbus(y, 1'b0));
    y.dcyc = 1'b0; y.dstb = 1'b0;
    add(y, o_dbus(y, 1'b0));
    add(y, o_idle(32'h22));
    add(y, o_ibus(32'h400, 1'b1, 1'b1, 1'b0, 32'h22));
    y.sack = 1'b1;
    add(y, o_ibus(32'h400, 1'b1, 1'b1, 1'b1, 32'h22));
    add(i_none(32'h0, 1'b0), o_idle(32'h0));
    // watchdog: slave never acks, fires in the 8th granted cycle
    x = i_ibus(32'h200, 32'hDEAD_BEEF);
    add(x, o_idle(32'hDEAD_BEEF));
    for (int k = 0; k < 7; k++) add(x, o_ibus(32'h200, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF));
    e = o_ibus(32'h200, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    e.idat = 32'h0;
    e.tmo  = 1'b1;
    add(x, e);
    add(i_none(32'hDEAD_BEEF, 1'b0), o_idle(32'hDEAD_BEEF));

    // ---------------- reset state ----------------
    wb_rst_i = 1'b1;
    drive(i_none(32'h55AA_0001, 1'b0));
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check_out("reset_idle", o_idle(32'h55AA_0001));
    drive(i_ibus(32'h100, 32'h55AA_0002));
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check_out("reset_hold_req", o_idle(32'h55AA_0002));
    drive(i_none(32'h0, 1'b0));
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // ---------------- apply table ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].vi);
      exp_q.push_back(vecs[i].ve);
      @(negedge wb_clk_i);
      check_out($sformatf("vec%0d", i), exp_q.pop_front());
      @(posedge wb_clk_i);
      #1;
    end

    // ---------------- async reset mid-DBUS cycle ----------------
    drive(i_dbus(32'h5000_0000, 32'h1234_5678, 1'b1, 4'hF, 32'h0));
    @(posedge wb_clk_i);
    #1;
    @(negedge wb_clk_i);
    check_bits("rst_pre_grant", {1'b0, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o}, 4'b0111);
    #2;
    m_wb_ack_i = 1'b1;
    wb_rst_i   = 1'b1;
    #1;
    check_bits("async_rst_outputs", {1'b0, m_wb_cyc_o, m_wb_stb_o, dbus_wb_ack_o}, 4'b0000);
    @(posedge wb_clk_i);
    #1;
    x = i_ibus(32'h1000, 32'h0);
    x.dcyc = 1'b1; x.dstb = 1'b1; x.dadr = 32'h2000; x.dsel = 4'hF;
    drive(x);
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // ---------------- tie-break order (1 = IBUS, 2 = DBUS) ----------------
`ifdef ARB_ROUND_ROBIN_EN
    gnt_q.push_back(1); gnt_q.push_back(2); gnt_q.push_back(1); gnt_q.push_back(2);
`else
    gnt_q.push_back(2); gnt_q.push_back(2); gnt_q.push_back(2); gnt_q.push_back(2);
`endif
    gnt_q.push_back(1);   // IBUS after DBUS stops requesting
    for (int k = 0; k < 5; k++) begin
      int who, want;
      bit got;
      got  = 1'b0;
      who  = 0;
      want = gnt_q.pop_front();
      for (int n = 0; n < 6 && !got; n++) begin
        @(negedge wb_clk_i);
        if (m_wb_cyc_o) begin
          got = 1'b1;
          who = (m_wb_adr_o == 32'h1000) ? 1 : (m_wb_adr_o == 32'h2000) ? 2 : 0;
        end
      end
      checks++;
      if (!got || who != want) begin
        errors++;
        $display("FAIL tie_grant%0d: got %0d want %0d (granted=%0d)", k, who, want, got);
      end
      if (got) begin
        m_wb_ack_i = 1'b1;
        #1;
        check_bits($sformatf("tie_ack%0d", k), {2'b00, ibus_wb_ack_o, dbus_wb_ack_o},
                   (want == 1) ? 4'b0010 : 4'b0001);
        @(posedge wb_clk_i);
        #1;
        m_wb_ack_i = 1'b0;
      end
      if (k == 3) begin
        dbus_wb_cyc_i = 1'b0;
        dbus_wb_stb_i = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ibus_dbus_arbiter.md
# wb_ibus_dbus_arbiter

Two-master to one-slave Wishbone arbiter that merges the Atom core's IBUS and DBUS master ports onto a single shared Wishbone master port. It sits between `AtomRV_wb` and a single-ported memory or interconnect. It grants one requester at a time, holds the grant for the whole bus cycle, and routes ack/data back only to the granted requester. An optional watchdog terminates cycles that the slave never acknowledges.

## Interface
- `TIMEOUT_CYCLES`, default 0: watchdog limit in cycles of an unacknowledged granted cycle; 0 disables the watchdog.
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  reset; asynchronous, active-high
- `ibus_wb_adr_i`  in  32  IBUS address
- `ibus_wb_dat_o`  out  32  IBUS read data
- `ibus_wb_cyc_i`, `ibus_wb_stb_i`  in  1  IBUS cycle/strobe
- `ibus_wb_ack_o`  out  1  IBUS acknowledge
- `dbus_wb_adr_i`  in  32  DBUS address
- `dbus_wb_dat_i`  in  32  DBUS write data
- `dbus_wb_dat_o`  out  32  DBUS read data
- `dbus_wb_cyc_i`, `dbus_wb_stb_i`, `dbus_wb_we_i`  in  1  DBUS cycle/strobe/write enable
- `dbus_wb_sel_i`  in  4  DBUS byte select
- `dbus_wb_ack_o`  out  1  DBUS acknowledge
- `m_wb_adr_o`  out  32  shared address
- `m_wb_dat_o`  out  32  shared write data
- `m_wb_dat_i`  in  32  shared read data
- `m_wb_cyc_o`, `m_wb_stb_o`, `m_wb_we_o`  out  1  shared cycle/strobe/write enable
- `m_wb_sel_o`  out  4  shared byte select
- `m_wb_ack_i`  in  1  shared acknowledge
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires

## Operation
- The FSM state register is `gnt`, with states IDLE, GNT_I and GNT_D. Reset value is IDLE.
- Requests:
  - IBUS requests when `ibus_wb_cyc_i & ibus_wb_stb_i`.
  - DBUS requests when `dbus_wb_cyc_i & dbus_wb_stb_i`.
- IDLE:
  - Only IBUS requesting: go to GNT_I.
  - Only DBUS requesting: go to GNT_D.
  - Both requesting: resolve per Configuration.
  - Neither requesting: stay in IDLE.
- GNT_x, with the shared port driven combinationally from the granted requester:
  - IBUS grant: `m_wb_we_o`=0 and `m_wb_sel_o`=4'b1111. `m_wb_dat_o` is IBUS-don't-care and is driven 0.
  - DBUS grant: address, data, `we` and `sel` pass through from DBUS.
  - `m_wb_cyc_o`/`m_wb_stb_o` follow the granted requester's `cyc`/`stb`.
- Ack routing:
  - `m_wb_ack_i` is routed to the granted requester's `ack` only. The non-granted ack is always 0.
  - `m_wb_dat_i` drives both `ibus_wb_dat_o` and `dbus_wb_dat_o`; requesters qualify it with their ack.
- GNT_x → IDLE on the edge where either:
  - `m_wb_ack_i`=1, or
  - the granted requester drops `cyc` (abort); no ack is generated on abort.
- Re-arbitration happens in IDLE on the following cycle. Every grant therefore has at least one IDLE cycle between bus cycles.
- IDLE outputs: all `m_wb_*` outputs are 0 and both acks are 0.
- Watchdog (`TIMEOUT_CYCLES`>0):
  - Counter `wd_cnt` has width `$clog2(TIMEOUT_CYCLES+1)`. It clears in IDLE and increments each GNT cycle without `m_wb_ack_i`.
  - When `wd_cnt`==`TIMEOUT_CYCLES`-1 and there is no ack, the arbiter does all of the following in that cycle:
    - drives the granted requester's ack=1 with its read data forced to 32'h0;
    - drives `m_wb_cyc_o`/`m_wb_stb_o`=0;
    - pulses `timeout_o`.
  - It then returns to IDLE at the next edge.
  - A real ack in the same cycle takes precedence: normal completion, no `timeout_o`.
- Asynchronous reset mid-cycle: `gnt`→IDLE, `wd_cnt`→0 and the last-grant register→DBUS, all immediately. All outputs fall to 0 combinationally.

## Timing
- Arbitration latency is 1 cycle: a request in IDLE at cycle n gives `m_wb_cyc_o`=1 in cycle n+1.
- Requester ack is combinational from `m_wb_ack_i`, with zero added latency.
- Minimum transaction is 2 cycles (grant + ack), followed by 1 IDLE cycle.
- Reset values:
  - all `m_wb_*` outputs = 0;
  - `ibus_wb_ack_o` = `dbus_wb_ack_o` = 0;
  - `timeout_o` = 0;
  - data outputs = `m_wb_dat_i` (pass-through).
- A slave ack arriving in IDLE is ignored.

## Configuration
- Macro `ARB_ROUND_ROBIN_EN` controls how simultaneous requests in IDLE are resolved:
  - Defined: a round-robin tie-break that grants the requester not served last. The last-grant register is updated on every entry to GNT_x and resets to DBUS, so IBUS wins the first tie.
  - Undefined: fixed priority, DBUS wins every tie. The last-grant register is not implemented.

## Test plan
- IBUS read of 0x0000_0100 with slave ack 1 cycle after stb and data 0x0000_0013:
  - `m_wb_cyc_o` rises 1 cycle after request, with `m_wb_we_o`=0 and `m_wb_sel_o`=4'hF;
  - `ibus_wb_ack_o`=1 with data 0x13;
  - `dbus_wb_ack_o` stays 0.
- DBUS write of 0xCAFEBABE to 0x2000_0004 with sel=4'b0011:
  - shared port shows identical adr/dat/sel with we=1;
  - ack is routed only to DBUS.
- IBUS and DBUS both request from reset, repeated for 4 transactions:
  - with `ARB_ROUND_ROBIN_EN`: grant order I, D, I, D;
  - without it: grant order D, D, D, D, and IBUS is served once DBUS stops requesting.
- DBUS granted, then DBUS drops `cyc` before any ack:
  - `m_wb_cyc_o` falls the same cycle and the FSM returns to IDLE;
  - a pending IBUS request is granted 1 cycle later;
  - no ack is issued.
- `TIMEOUT_CYCLES`=8, slave never acks an IBUS request:
  - in the 8th granted cycle, `ibus_wb_ack_o`=1 with data 0 and `timeout_o` pulses for 1 cycle;
  - `m_wb_cyc_o` is 0 in that cycle.
- Assert `wb_rst_i` asynchronously mid-DBUS cycle:
  - `m_wb_cyc_o`/`m_wb_stb_o`/`dbus_wb_ack_o` are 0 before the next clock edge;
  - after reset the first tie goes to IBUS (round-robin) or DBUS (fixed).
